// File: rtl/axis_adc_decimator.sv
// Block-averaging decimator: sums 2^L ADC samples and emits one average per block on an AXI-Stream master.
// Optional build macro DECIM_ROUND_EN selects round-half-up with 16-bit saturation instead of truncation.
module axis_adc_decimator #(
  parameter int LOG2_MAX  = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_en,
  input  logic [3:0]           cfg_log2,
  input  logic                 s_axis_tvalid,
  input  logic [31:0]          s_axis_tdata,
  output logic                 s_axis_tready,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 sts_overrun,
  output logic [CNT_WIDTH-1:0] sts_overrun_cnt
);

  // state   | meaning
  // IDLE    | disabled; accumulator and counter held at zero
  // LOAD    | one cycle; latch clamped exponent for the first block
  // ACCUM   | accept samples; re-latch exponent at each block boundary

  localparam int AW = 16 + LOG2_MAX;
  localparam int CW = LOG2_MAX + 1;
  localparam logic [3:0] LMAX = 4'(LOG2_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;

  logic [1:0]           state;
  logic [3:0]           lr;
  logic [3:0]           lr_cfg;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] sample_ext;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        blk_last;
  logic                 accept;
  logic                 done;
  logic [15:0]          avg;
  logic [15:0]          avg_q;

  assign s_axis_tready = 1'b1;

  always_comb begin
    lr_cfg     = (cfg_log2 > LMAX) ? LMAX : cfg_log2;
    sample_ext = {{LOG2_MAX{s_axis_tdata[15]}}, s_axis_tdata[15:0]};
    sum        = acc + sample_ext;
    blk_last   = (CW'(1) << lr) - CW'(1);
    accept     = (state == S_ACCUM) && cfg_en && s_axis_tvalid;
    done       = accept && (cnt == blk_last);
  end

`ifdef DECIM_ROUND_EN
  localparam logic signed [AW:0] SAT_HI = (AW+1)'(32767);
  localparam logic signed [AW:0] SAT_LO = (AW+1)'(-32768);

  logic signed [AW:0] sum_w;
  logic signed [AW:0] rnd;
  logic signed [AW:0] shifted;
  logic               unused_bits;

  always_comb begin
    sum_w   = {sum[AW-1], sum};
    rnd     = (lr == 4'd0) ? '0 : ((AW+1)'(1) << (lr - 4'd1));
    shifted = (sum_w + rnd) >>> lr;
    if (shifted > SAT_HI)
      avg = 16'h7fff;
    else if (shifted < SAT_LO)
      avg = 16'h8000;
    else
      avg = shifted[15:0];
  end

  assign unused_bits = ^s_axis_tdata[31:16];
`else
  logic signed [AW-1:0] shifted;
  logic                 unused_bits;

  always_comb begin
    shifted = sum >>> lr;
    avg     = shifted[15:0];
  end

  // The average of 16-bit samples always fits in 16 bits; upper bits are sign copies.
  assign unused_bits = ^{s_axis_tdata[31:16], shifted[AW-1:16]};
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_IDLE;
      lr    <= 4'd0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          acc <= '0;
          cnt <= '0;
          if (cfg_en)
            state <= S_LOAD;
        end
        S_LOAD: begin
          acc   <= '0;
          cnt   <= '0;
          lr    <= lr_cfg;
          state <= cfg_en ? S_ACCUM : S_IDLE;
        end
        S_ACCUM: begin
          if (!cfg_en) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (s_axis_tvalid) begin
            if (done) begin
              // Next block starts on the very next accept with the new exponent.
              acc <= '0;
              cnt <= '0;
              lr  <= lr_cfg;
            end else begin
              acc <= sum;
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          acc   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid   <= 1'b0;
      avg_q           <= 16'h0000;
      sts_overrun     <= 1'b0;
      sts_overrun_cnt <= '0;
    end else begin
      if (done) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tvalid <= 1'b1;
          avg_q         <= avg;
        end else begin
          sts_overrun <= 1'b1;
          if (sts_overrun_cnt != {CNT_WIDTH{1'b1}})
            sts_overrun_cnt <= sts_overrun_cnt + CNT_WIDTH'(1);
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata = {avg_q, avg_q};

endmodule

// File: doc/axis_adc_decimator.md
# axis_adc_decimator

Block-averaging decimator directly downstream of the ADC capture stage. Consumes the always-valid 32-bit ADC stream (two copies of a signed 16-bit sample), sums 2^L consecutive samples, and emits one arithmetic-shifted average per block on a back-pressured AXI-Stream master. A single-entry output register with overrun detection absorbs downstream stalls, because the ADC side cannot be stalled.

## Interface
Parameters:
- LOG2_MAX, 10, maximum decimation exponent; accumulator width = 16 + LOG2_MAX.
- CNT_WIDTH, 16, width of the overrun counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- cfg_en  in  1  decimator enable; low flushes the block in progress.
- cfg_log2  in  4  decimation exponent L; ratio 2^L; values > LOG2_MAX clamp to LOG2_MAX.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tdata  in  32  input; bits [15:0] are the signed sample, bits [31:16] are ignored.
- s_axis_tready  out  1  tied to 1.
- m_axis_tvalid  out  1  output average valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  32  {avg[15:0], avg[15:0]}.
- sts_overrun  out  1  sticky; set on any dropped result; cleared only by reset.
- sts_overrun_cnt  out  CNT_WIDTH  dropped-result count; saturates at all-ones.

## Operation
- FSM states:
  - IDLE: entered on reset or whenever cfg_en = 0. Clears the accumulator and sample counter; no accepts.
  - LOAD: entered when cfg_en = 1. Latches Lr = clamp(cfg_log2) for the next block. Single cycle, no accepts. Goes to ACCUM.
  - ACCUM: each cycle with s_axis_tvalid = 1, adds the sign-extended sample to the accumulator and increments the counter.
- Block completion: the accept that brings the counter to 2^Lr completes the block.
  - On that edge: result = (acc + sample) >>> Lr, arithmetic shift; accumulator and counter reset to 0.
  - The FSM stays in ACCUM with Lr re-latched from cfg_log2, so the next sample accepted in the very next cycle belongs to the new block and no samples are lost.
  - A cfg_log2 change takes effect only at a block boundary. A block in progress finishes with its latched Lr.
- Lr = 0: every sample is its own block; the output is the sample itself.
- Output register:
  - If m_axis_tvalid = 0, or m_axis_tready = 1 in the same cycle, a completed result loads it and m_axis_tvalid = 1.
  - Otherwise the new result is dropped, the held result is unchanged, sts_overrun is set, and sts_overrun_cnt increments (saturating).
  - A handshake with no new result clears m_axis_tvalid.
- cfg_en falling mid-block: the partial sum is discarded and nothing is emitted. A result already held in the output register stays valid until it is accepted.
- Accumulator width is 16 + LOG2_MAX signed and cannot overflow.
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, sts_overrun 0, sts_overrun_cnt 0, accumulator 0, counter 0, state IDLE.

## Timing
- Reset is asynchronous assert, synchronous-to-aclk deassert as seen by the logic. Outputs go to reset values immediately on assertion.
- cfg_en rise to first accepted sample: 1 cycle (the LOAD cycle).
- Latency: m_axis_tvalid is high in the cycle after the accept cycle of the block's last sample.
- Throughput: one result per 2^Lr valid input cycles; no bubble between blocks.
- m_axis_tdata stays stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- Simultaneous handshake and new result: the new result loads in the same cycle and m_axis_tvalid stays 1; this is not an overrun.

## Configuration
- DECIM_ROUND_EN defined:
  - result = (sum + 2^(Lr-1)) >>> Lr for Lr > 0 (round half up).
  - The result saturates to the 16-bit signed range [-32768, 32767].
  - Lr = 0 is unchanged.
- DECIM_ROUND_EN undefined: plain arithmetic shift, truncating toward negative infinity; no saturation logic is built.

## Test plan
- Reset, cfg_en = 1, L = 2, constant samples 0x0100, tready = 1 -> one result 0x01000100 every 4 cycles; first m_axis_tvalid 1 + 4 + 1 cycles after cfg_en rises.
- L = 1, samples -3, -4 (truncation build) -> avg 0xFFFC (-4). Same stimulus with DECIM_ROUND_EN -> -3 (0xFFFD). Samples 32767, 32767 with DECIM_ROUND_EN -> 32767, no wrap.
- L = 0, ramp 0..9 with tready toggling every cycle -> only accepted values appear, in order; dropped values raise sts_overrun, and sts_overrun_cnt equals the number dropped.
- L = 3, tready held 0 for 40 cycles -> first result held unchanged; 4 further blocks complete, so sts_overrun_cnt = 4; releasing tready delivers the held result first.
- Change cfg_log2 from 2 to 4 after the 2nd sample of a block -> that block still averages 4 samples; the next block averages 16.
- Drop cfg_en after 3 of 8 samples, re-enable -> no partial output; the next result averages exactly 8 fresh samples. Assert aresetn mid-block -> all outputs return to their reset values immediately.
